alu_op_sequencer: RTL and testbench

Sequential front-end for the 8-bit combinational ALU (A, B, 4-bit ALU_Sel, ALU_Out, CarryOut). It accepts operation commands over a valid/ready handshake and registers operands onto the ALU inputs. It captures ALU_Out/CarryOut after one settle cycle and presents a held response with flag post-processing and a completed-op counter. It sits directly upstream of the ALU, and its response port feeds the register-file/writeback logic.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_op_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode map of the
// downstream 8-bit ALU, sequencer state encoding and the divide-by-zero fill.
package alu_seq_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] OP_ADD  = 4'h0;
  localparam logic [ALU_SEL_W-1:0] OP_SUB  = 4'h1;
  localparam logic [ALU_SEL_W-1:0] OP_MUL  = 4'h2;
  localparam logic [ALU_SEL_W-1:0] OP_DIV  = 4'h3;
  localparam logic [ALU_SEL_W-1:0] OP_SHL  = 4'h4;
  localparam logic [ALU_SEL_W-1:0] OP_SHR  = 4'h5;
  localparam logic [ALU_SEL_W-1:0] OP_ROL  = 4'h6;
  localparam logic [ALU_SEL_W-1:0] OP_ROR  = 4'h7;
  localparam logic [ALU_SEL_W-1:0] OP_AND  = 4'h8;
  localparam logic [ALU_SEL_W-1:0] OP_OR   = 4'h9;
  localparam logic [ALU_SEL_W-1:0] OP_XOR  = 4'hA;
  localparam logic [ALU_SEL_W-1:0] OP_NOR  = 4'hB;
  localparam logic [ALU_SEL_W-1:0] OP_NAND = 4'hC;
  localparam logic [ALU_SEL_W-1:0] OP_XNOR = 4'hD;
  localparam logic [ALU_SEL_W-1:0] OP_GT   = 4'hE;
  localparam logic [ALU_SEL_W-1:0] OP_EQ   = 4'hF;

  // Result reported in place of the ALU output when dividing by zero.
  localparam logic [ALU_WIDTH-1:0] DIVZ_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequential front-end for the combinational 8-bit ALU. Commands arrive over a
// valid/ready handshake, operands are registered onto the ALU inputs, the ALU
// output is captured after one settle cycle and held as a response with
// qualified carry, divide-by-zero detection and a completed-operation counter.
// cmd_ready depends combinationally on rsp_ready while a response is held, so
// a new command can be accepted in the same cycle the old response retires.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_divz,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_data_d;
  logic             rsp_carry_q;
  logic             rsp_carry_d;
  logic             rsp_divz_q;
  logic             rsp_divz_d;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;
  logic             rsp_fire;

  assign cmd_ready  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign rsp_fire   = rsp_valid_q && rsp_ready;
  assign op_count_d = op_count_q + CNT_W'(1);

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_divz  = rsp_divz_q;
  assign op_count  = op_count_q;

  // Flag post-processing of the settled ALU result: divide-by-zero overrides
  // the ALU output with the all-ones DIVZ_RESULT pattern, carry only for ADD.
  always_comb begin
    rsp_data_d  = alu_out;
    rsp_carry_d = 1'b0;
    rsp_divz_d  = 1'b0;
    if ((alu_sel_q == SEL_W'(OP_DIV)) && (alu_b_q == '0)) begin
      rsp_data_d = '1;
      rsp_divz_d = 1'b1;
    end else if (alu_sel_q == SEL_W'(OP_ADD)) begin
      rsp_carry_d = alu_carry;
    end
  end

  // Handshake FSM: load operands on accept, capture after one settle cycle,
  // hold the response until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_divz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q   <= cmd_a;
            alu_b_q   <= cmd_b;
            alu_sel_q <= cmd_sel;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= rsp_data_d;
          rsp_carry_q <= rsp_carry_d;
          rsp_divz_q  <= rsp_divz_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (cmd_valid) begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_sel;
              state_q   <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completed-response counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_fire) begin
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural 8-bit ALU model.
// A second instance with a 4-bit counter shares the command stream so that
// counter wrap can be observed within a short run.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmdValid;
  logic       cmdReady;
  logic [7:0] cmdA;
  logic [7:0] cmdB;
  logic [3:0] cmdSel;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [3:0] aluSel;
  logic [7:0] aluOut;
  logic       aluCarry;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic       rspCarry;
  logic       rspDivz;
  logic [15:0] opCount;

  logic       cmdReadyW;
  logic [7:0] aluAW;
  logic [7:0] aluBW;
  logic [3:0] aluSelW;
  logic [7:0] aluOutW;
  logic       aluCarryW;
  logic       rspValidW;
  logic [7:0] rspDataW;
  logic       rspCarryW;
  logic       rspDivzW;
  logic [3:0] opCountW;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model of the downstream ALU; CarryOut is always the ADD carry.
  function automatic logic [8:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      4'h0: res = a + b;
      4'h1: res = a - b;
      4'h2: res = a * b;
      4'h3: res = (b == 8'h00) ? 8'h55 : a / b;
      4'h4: res = a << 1;
      4'h5: res = a >> 1;
      4'h6: res = {a[6:0], a[7]};
      4'h7: res = {a[0], a[7:1]};
      4'h8: res = a & b;
      4'h9: res = a | b;
      4'hA: res = a ^ b;
      4'hB: res = ~(a | b);
      4'hC: res = ~(a & b);
      4'hD: res = ~(a ^ b);
      4'hE: res = (a > b) ? 8'h01 : 8'h00;
      default: res = (a == b) ? 8'h01 : 8'h00;
    endcase
    return {sum[8], res};
  endfunction

  assign {aluCarry, aluOut}   = aluModel(aluA, aluB, aluSel);
  assign {aluCarryW, aluOutW} = aluModel(aluAW, aluBW, aluSelW);

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_a(cmdA), .cmd_b(cmdB), .cmd_sel(cmdSel),
    .alu_a(aluA), .alu_b(aluB), .alu_sel(aluSel),
    .alu_out(aluOut), .alu_carry(aluCarry),
    .rsp_valid(rspValid), .rsp_ready(rspReady),
    .rsp_data(rspData), .rsp_carry(rspCarry), .rsp_divz(rspDivz),
    .op_count(opCount)
  );

  alu_op_sequencer #(.WIDTH(8), .SEL_W(4), .CNT_W(4)) dutWrap (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmdValid), .cmd_ready(cmdReadyW),
    .cmd_a(cmdA), .cmd_b(cmdB), .cmd_sel(cmdSel),
    .alu_a(aluAW), .alu_b(aluBW), .alu_sel(aluSelW),
    .alu_out(aluOutW), .alu_carry(aluCarryW),
    .rsp_valid(rspValidW), .rsp_ready(rspReady),
    .rsp_data(rspDataW), .rsp_carry(rspCarryW), .rsp_divz(rspDivzW),
    .op_count(opCountW)
  );

  // Drive a command from a negedge and return at the negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    int n;
    cmdA = a;
    cmdB = b;
    cmdSel = sel;
    cmdValid = 1'b1;
    n = 0;
    #1;
    while (!cmdReady && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    testsRun++;
    if (n >= 20) begin
      testsFailed++;
      $display("[TB] FAIL acceptTimeout: cmd_ready got %b expected 1", cmdReady);
    end
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  // Count edges until rsp_valid shows, bounded.
  task automatic waitRsp(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end while (!rspValid && edges < 10);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    testsRun++;
    if ({rspValid, rspCarry, rspDivz} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL resetFlags: got %b expected 000", {rspValid, rspCarry, rspDivz});
    end
    testsRun++;
    if ({aluA, aluB, aluSel, rspData} !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetRegs: got %h expected 0", {aluA, aluB, aluSel, rspData});
    end
    testsRun++;
    if (opCount !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetCount: got %h expected 0000", opCount);
    end
    rst_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if (cmdReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL resetReady: got %b expected 1", cmdReady);
    end
  endtask

  task automatic test_add();
    int edges;
    applyStimulus(8'h0A, 8'h02, OP_ADD);
    testsRun++;
    if (rspValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL addEarly: rsp_valid got %b expected 0", rspValid);
    end
    waitRsp(edges);
    testsRun++;
    if (edges !== 1) begin
      testsFailed++;
      $display("[TB] FAIL addLatency: got %0d expected 1 edge after accept", edges);
    end
    testsRun++;
    if ({rspData, rspCarry, rspDivz} !== {8'h0C, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL addResult: got %h/%b/%b expected 0c/0/0", rspData, rspCarry, rspDivz);
    end
    @(negedge clk);
    testsRun++;
    if (opCount !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL addCount: got %0d expected 1", opCount);
    end
  endtask

  task automatic test_add_carry();
    int edges;
    applyStimulus(8'hF6, 8'h0A, OP_ADD);
    waitRsp(edges);
    testsRun++;
    if ({rspData, rspCarry} !== {8'h00, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL addCarry: got %h/%b expected 00/1", rspData, rspCarry);
    end
    applyStimulus(8'hF6, 8'h0A, OP_SUB);
    waitRsp(edges);
    testsRun++;
    if ({rspData, rspCarry} !== {8'hEC, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL subCarryMask: got %h/%b expected ec/0", rspData, rspCarry);
    end
    @(negedge clk);
    testsRun++;
    if (opCount !== 16'd3) begin
      testsFailed++;
      $display("[TB] FAIL carryCount: got %0d expected 3", opCount);
    end
  endtask

  task automatic test_divz();
    int edges;
    applyStimulus(8'h0A, 8'h00, OP_DIV);
    waitRsp(edges);
    testsRun++;
    if ({rspData, rspDivz, rspCarry} !== {8'hFF, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL divZero: got %h/%b/%b expected ff/1/0", rspData, rspDivz, rspCarry);
    end
    applyStimulus(8'h0A, 8'h02, OP_DIV);
    waitRsp(edges);
    testsRun++;
    if ({rspData, rspDivz} !== {8'h05, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL divNormal: got %h/%b expected 05/0", rspData, rspDivz);
    end
    @(negedge clk);
    testsRun++;
    if (opCount !== 16'd5) begin
      testsFailed++;
      $display("[TB] FAIL divCount: got %0d expected 5", opCount);
    end
  endtask

  task automatic test_backpressure();
    int edges;
    rspReady = 1'b0;
    applyStimulus(8'h33, 8'h11, OP_XOR);
    waitRsp(edges);
    testsRun++;
    if (rspData !== 8'h22) begin
      testsFailed++;
      $display("[TB] FAIL bpFirst: got %h expected 22", rspData);
    end
    cmdA = 8'h0C;
    cmdB = 8'h05;
    cmdSel = OP_AND;
    cmdValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      testsRun++;
      if ({rspValid, rspData, cmdReady} !== {1'b1, 8'h22, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL bpHoldRsp: got %b/%h/%b expected 1/22/0", rspValid, rspData, cmdReady);
      end
      testsRun++;
      if ({aluA, aluB, aluSel, opCount} !== {8'h33, 8'h11, OP_XOR, 16'd5}) begin
        testsFailed++;
        $display("[TB] FAIL bpHoldAlu: got %h/%h/%h/%0d expected 33/11/a/5", aluA, aluB, aluSel, opCount);
      end
    end
    rspReady = 1'b1;
    #1;
    testsRun++;
    if (cmdReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bpReadyPath: got %b expected 1", cmdReady);
    end
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    testsRun++;
    if ({rspValid, aluA, aluB, aluSel, opCount} !== {1'b0, 8'h0C, 8'h05, OP_AND, 16'd6}) begin
      testsFailed++;
      $display("[TB] FAIL bpAccept: got %b/%h/%h/%h/%0d expected 0/0c/05/8/6", rspValid, aluA, aluB, aluSel, opCount);
    end
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({rspValid, rspData} !== {1'b1, 8'h04}) begin
      testsFailed++;
      $display("[TB] FAIL bpSecond: got %b/%h expected 1/04", rspValid, rspData);
    end
    @(negedge clk);
    testsRun++;
    if (opCount !== 16'd7) begin
      testsFailed++;
      $display("[TB] FAIL bpCount: got %0d expected 7", opCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expData [16];
    expData = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rspReady = 1'b1;
    cmdA = 8'h0A;
    cmdB = 8'h02;
    cmdSel = 4'h0;
    cmdValid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 15) cmdSel = 4'(k + 1);
      else cmdValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      testsRun++;
      if ({rspValid, rspData, rspCarry, rspDivz} !== {1'b1, expData[k], 1'b0, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL sweepSel%0h: got %b/%h/%b/%b expected 1/%h/0/0", k, rspValid, rspData, rspCarry, rspDivz, expData[k]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    testsRun++;
    if ({rspValid, opCount} !== {1'b0, 16'd23}) begin
      testsFailed++;
      $display("[TB] FAIL sweepCount: got %b/%0d expected 0/23", rspValid, opCount);
    end
  endtask

  task automatic test_reset_mid_op();
    int edges;
    int spurious;
    applyStimulus(8'h0A, 8'h02, OP_ADD);
    waitRsp(edges);
    @(negedge clk);
    applyStimulus(8'h30, 8'h03, OP_MUL);
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({rspValid, aluA, aluB, aluSel, rspData} !== 29'h0) begin
      testsFailed++;
      $display("[TB] FAIL midResetRegs: got %h expected 0", {rspValid, aluA, aluB, aluSel, rspData});
    end
    testsRun++;
    if ({opCount, opCountW, cmdReady} !== {16'h0, 4'h0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL midResetCount: got %h/%h/%b expected 0000/0/1", opCount, opCountW, cmdReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (rspValid !== 1'b0) spurious++;
    end
    testsRun++;
    if (spurious !== 0 || cmdReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midResetAfter: spurious %0d cmd_ready %b expected 0 and 1", spurious, cmdReady);
    end
  endtask

  task automatic test_count_wrap();
    int edges;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(8'(i), 8'h01, OP_ADD);
      waitRsp(edges);
    end
    @(negedge clk);
    testsRun++;
    if ({opCountW, opCount} !== {4'hF, 16'd15}) begin
      testsFailed++;
      $display("[TB] FAIL wrapPreload: got %h/%0d expected f/15", opCountW, opCount);
    end
    applyStimulus(8'h40, 8'h40, OP_ADD);
    waitRsp(edges);
    testsRun++;
    if ({rspValidW, rspDataW, rspCarryW, rspDivzW, cmdReadyW} !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL wrapRsp: got %b/%h/%b/%b/%b expected 1/80/0/0/1", rspValidW, rspDataW, rspCarryW, rspDivzW, cmdReadyW);
    end
    @(negedge clk);
    testsRun++;
    if ({opCountW, opCount} !== {4'h0, 16'd16}) begin
      testsFailed++;
      $display("[TB] FAIL wrapCount: got %h/%0d expected 0/16", opCountW, opCount);
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    cmdValid = 1'b0;
    cmdA = 8'h00;
    cmdB = 8'h00;
    cmdSel = 4'h0;
    rspReady = 1'b1;
    test_reset();
    test_add();
    test_add_carry();
    test_divz();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
